// File: rtl/grid_scan_controller.sv
// Row-major sweep of a GRID_W x GRID_H cell classifier, packing each row into a word for the frame buffer.
// Optional macro SCAN_HOLD_EN adds a hold input that pauses the sweep in SCAN.
module grid_scan_controller #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 12,
  parameter int COORD_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef SCAN_HOLD_EN
  input  logic               hold,
`endif
  input  logic               cell_in,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [GRID_W-1:0]  row_data,
  output logic [COORD_W-1:0] row_addr,
  output logic               row_wr,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  state_t             state_reg, state_next;
  logic [COORD_W-1:0] x_reg, x_next;
  logic [COORD_W-1:0] y_reg, y_next;
  logic [COORD_W-1:0] row_addr_reg, row_addr_next;
  logic [GRID_W-1:0]  pack_reg, pack_next;
  logic [GRID_W-1:0]  row_data_reg, row_data_next;
  logic [GRID_W-1:0]  captured;
  logic               row_wr_reg, row_wr_next;
  logic               hold_active;
  logic               last_x, last_y;

`ifdef SCAN_HOLD_EN
  assign hold_active = hold;
`else
  assign hold_active = 1'b0;
`endif

  // Packing register with the current cell merged in at bit x.
  generate
    for (genvar gi = 0; gi < GRID_W; gi++) begin : g_capture
      assign captured[gi] = (x_reg == COORD_W'(gi)) ? cell_in : pack_reg[gi];
    end
  endgenerate

  assign last_x = (x_reg == COORD_W'(GRID_W - 1));
  assign last_y = (y_reg == COORD_W'(GRID_H - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      pack_reg     <= '0;
      row_data_reg <= '0;
      row_addr_reg <= '0;
      row_wr_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      pack_reg     <= pack_next;
      row_data_reg <= row_data_next;
      row_addr_reg <= row_addr_next;
      row_wr_reg   <= row_wr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    pack_next     = pack_reg;
    row_data_next = row_data_reg;
    row_addr_next = row_addr_reg;
    row_wr_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        x_next    = '0;
        y_next    = '0;
        pack_next = '0;
        if (start) state_next = SCAN;
      end
      SCAN: begin
        if (!hold_active) begin
          if (last_x) begin
            // Row complete: hand the word off and restart packing with no bubble.
            row_data_next = captured;
            row_addr_next = y_reg;
            row_wr_next   = 1'b1;
            pack_next     = '0;
            x_next        = '0;
            if (last_y) begin
              y_next     = '0;
              state_next = FLUSH;
            end else begin
              y_next = y_reg + COORD_W'(1);
            end
          end else begin
            pack_next = captured;
            x_next    = x_reg + COORD_W'(1);
          end
        end
      end
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign x        = x_reg;
  assign y        = y_reg;
  assign row_data = row_data_reg;
  assign row_addr = row_addr_reg;
  assign row_wr   = row_wr_reg;
  assign busy     = (state_reg == SCAN) || (state_reg == FLUSH);
  assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_grid_scan_controller.sv
// Randomised and directed bench for grid_scan_controller, checked every cycle against a sweep-count model.
module tb_grid_scan_controller;
  localparam int W = 16;
  localparam int H = 12;
  localparam int CW = 4;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic cell_in;
  logic [CW-1:0] x, y, row_addr;
  logic [W-1:0] row_data;
  logic row_wr, busy, done;

  logic cmap [0:H-1][0:W-1];

  grid_scan_controller #(.GRID_W(W), .GRID_H(H), .COORD_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef SCAN_HOLD_EN
    .hold(hold),
`endif
    .cell_in(cell_in),
    .x(x),
    .y(y),
    .row_data(row_data),
    .row_addr(row_addr),
    .row_wr(row_wr),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Combinational classifier: lookup into the current cell map.
  assign cell_in = (int'(x) < W && int'(y) < H) ? cmap[y][x] : 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model: a sweep is a count of sampled cells plus two trailing cycles.
  bit          m_active = 1'b0;
  int          m_n = 0;
  int          m_post = 0;
  bit          m_wr = 1'b0;
  logic [W-1:0] m_data = '0;
  int          m_addr = 0;
  int          m_e0 = 0;

  logic [W-1:0] wr_data_q[$];
  int           wr_addr_q[$];
  int           wr_off_q[$];
  int           done_cnt = 0;
  int           done_off = 0;
  int           done_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rowval(input int r);
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < W; c++) v[c] = cmap[r][c];
    return v;
  endfunction

  task automatic set_map(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0: cmap[r][c] = (c == 0 || c == W-1 || r == 0 || r == H-1);
          1: cmap[r][c] = 1'b0;
          2: cmap[r][c] = (c == r);
          default: cmap[r][c] = 1'($urandom_range(0, 1));
        endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_active = 1'b0; m_n = 0; m_post = 0; m_wr = 1'b0; m_data = '0; m_addr = 0;
      end else if (!m_active) begin
        m_wr = 1'b0;
        if (start) begin
          m_active = 1'b1; m_n = 0; m_post = 0; m_e0 = cyc;
        end
      end else if (m_n < N) begin
        m_wr = 1'b0;
        if (!hold) begin
          m_n++;
          if (m_n % W == 0) begin
            m_wr = 1'b1;
            m_addr = m_n / W - 1;
            m_data = rowval(m_addr);
          end
          if (m_n == N) m_post = 1;
        end
      end else if (m_post == 1) begin
        m_post = 2; m_wr = 1'b0;
      end else begin
        m_active = 1'b0; m_post = 0;
      end
    end
  end

  // Compare process: every output, every cycle, plus transaction recording.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit scanning;
        scanning = m_active && m_n < N;
        chk("x", 32'(x), scanning ? 32'(m_n % W) : 32'd0);
        chk("y", 32'(y), scanning ? 32'(m_n / W) : 32'd0);
        chk("busy", 32'(busy), 32'(m_active && m_post < 2));
        chk("done", 32'(done), 32'(m_active && m_post == 2));
        chk("row_wr", 32'(row_wr), 32'(m_wr));
        chk("row_data", 32'(row_data), 32'(m_data));
        chk("row_addr", 32'(row_addr), 32'(m_addr));
        if (row_wr) begin
          wr_data_q.push_back(row_data);
          wr_addr_q.push_back(int'(row_addr));
          wr_off_q.push_back(cyc - m_e0);
          $display("row_wr addr %0d data %h offset %0d", row_addr, row_data, cyc - m_e0);
        end
        if (done) begin
          done_cnt++;
          done_off = cyc - m_e0;
          done_cyc = cyc;
          $display("done offset %0d", cyc - m_e0);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rec();
    wr_data_q.delete(); wr_addr_q.delete(); wr_off_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      step();
      if (done_cnt > d0) seen = 1'b1;
    end
    chk("wait_done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_xy(input int wx, input int wy, input int bound);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      if (int'(x) == wx && int'(y) == wy && busy) seen = 1'b1;
      else step();
    end
    chk("wait_xy_timeout", 32'(seen), 32'd1);
  endtask

  // Literal expectations for a whole sweep; rows from delay_row onward shift by delay.
  task automatic check_sweep(input int mode, input int delay, input int delay_row);
    logic [W-1:0] e;
    chk("strobe_count", 32'(wr_data_q.size()), 32'd12);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("done_offset", 32'(done_off), 32'(193 + delay));
    for (int r = 0; r < H && r < wr_data_q.size(); r++) begin
      case (mode)
        0: e = (r == 0 || r == 11) ? 16'hFFFF : 16'h8001;
        1: e = 16'h0000;
        default: e = 16'h0001 << r;
      endcase
      chk("sweep_row_data", 32'(wr_data_q[r]), 32'(e));
      chk("sweep_row_addr", 32'(wr_addr_q[r]), 32'(r));
      chk("sweep_row_offset", 32'(wr_off_q[r]), 32'(16 * (r + 1) + (r >= delay_row ? delay : 0)));
    end
  endtask

  initial begin
    int first_done;
    set_map(0);
    rst = 1'b1;
    @(posedge clk);
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    chk("reset_x", 32'(x), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_row_data", 32'(row_data), 32'd0);

    // Border sweep with nominal timing.
    clear_rec(); pulse_start(); wait_done(400); check_sweep(0, 0, 0);
    step(); step();

    // All-zero classifier.
    set_map(1); clear_rec(); pulse_start(); wait_done(400); check_sweep(1, 0, 0);
    step();

    // Diagonal classifier with a stray start mid-sweep.
    set_map(2); clear_rec(); pulse_start();
    for (int k = 0; k < 48; k++) step();
    pulse_start();
    wait_done(400); check_sweep(2, 0, 0);
    for (int k = 0; k < 5; k++) step();
    chk("no_extra_done", 32'(done_cnt), 32'd1);

    // Reset in the middle of row 5.
    set_map(0); clear_rec(); pulse_start();
    wait_xy(7, 5, 300);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_row_wr", 32'(row_wr), 32'd0);
    chk("midrst_row_data", 32'(row_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_y", 32'(y), 32'd0);
    chk("midrst_strobes", 32'(wr_data_q.size()), 32'd5);
    for (int k = 0; k < 20; k++) step();
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    clear_rec(); pulse_start(); wait_done(400); check_sweep(0, 0, 0);
    step();

    // Start held high: back-to-back sweeps with one idle cycle between.
    clear_rec();
    start = 1'b1;
    wait_done(400);
    first_done = done_cyc;
    wait_done(400);
    start = 1'b0;
    chk("held_restart_gap", 32'(m_e0 - first_done), 32'd2);
    chk("held_strobes", 32'(wr_data_q.size()), 32'd24);
    step(); step(); step();

`ifdef SCAN_HOLD_EN
    // Hold for ten cycles at (3,2).
    set_map(0); clear_rec(); pulse_start();
    wait_xy(3, 2, 300);
    hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_x", 32'(x), 32'd3);
      chk("hold_y", 32'(y), 32'd2);
    end
    hold = 1'b0;
    wait_done(400); check_sweep(0, 10, 2);
    step();
`endif

    // Random traffic: starts, holds, rare resets, fresh random maps per sweep.
    set_map(3);
    for (int k = 0; k < 3000; k++) begin
      step();
      start = ($urandom_range(0, 7) == 0);
`ifdef SCAN_HOLD_EN
      hold = ($urandom_range(0, 9) == 0);
`endif
      rst = ($urandom_range(0, 499) == 0);
      if (done) set_map(3);
    end
    start = 1'b0; hold = 1'b0; rst = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
